// File: rtl/hilo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hilo_pkg
// Brief   : Shared op codes, FSM state encoding and default width for hilo_ctrl
// Revision: 1.0  initial release
// ============================================================================
package hilo_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_WB   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/hilo_ctrl_div_iter.sv
`default_nettype none
// ============================================================================
// Module  : div_iter
// Brief   : Restoring radix-2 unsigned divider, one quotient bit per cycle
// Revision: 1.0  initial release
// ============================================================================
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             last,
    output logic [WIDTH-1:0] quo_next,
    output logic [WIDTH-1:0] rem_next
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;
    logic             active;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             take;

    // Remainder stays below the divisor, so the shifted trial value fits WIDTH+1 bits.
    assign shifted  = {rem, quo[WIDTH-1]};
    assign diff     = shifted - {1'b0, dvs};
    assign take     = ~diff[WIDTH];
    assign rem_next = take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], take};
    assign last     = active && (cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (start) begin
            rem    <= '0;
            quo    <= dividend;
            dvs    <= divisor;
            cnt    <= '0;
            active <= 1'b1;
        end else if (active) begin
            rem <= rem_next;
            quo <= quo_next;
            cnt <= cnt + 1'b1;
            if (last) begin
                active <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hilo_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hilo_ctrl
// Brief   : HI/LO sequencer: multiply, divide, MTHI/MTLO with one-cycle write-back
// Revision: 1.0  initial release
// ============================================================================
module hilo_ctrl
    import hilo_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic             hi_wea,
    output logic [WIDTH-1:0] hi_wdata,
    output logic             lo_wea,
    output logic [WIDTH-1:0] lo_wdata,
    output logic             done,
    output logic             div_zero
);
    localparam logic [2:0] MUL_LAST = 3'(MUL_LAT - 1);

    state_t           state, state_nxt;
    logic [2:0]       cnt;
    logic             accept;
    logic             is_div, div_signed, rt_zero;
    logic [WIDTH-1:0] rs_mag, rt_mag;
    logic [WIDTH-1:0] mul_a, mul_b;
    logic             mul_signed, q_neg, r_neg;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod;
    logic             div_last;
    logic [WIDTH-1:0] quo_next, rem_next;
    logic             hi_wea_nxt, lo_wea_nxt, done_nxt, div_zero_nxt;
    logic [WIDTH-1:0] hi_wdata_nxt, lo_wdata_nxt;

    assign busy       = (state != S_IDLE);
    assign accept     = op_valid && (state == S_IDLE) && (op_code != OP_NONE) && (op_code != 3'd7);
    assign is_div     = (op_code == OP_DIV) || (op_code == OP_DIVU);
    assign div_signed = (op_code == OP_DIV);
    assign rt_zero    = (rt_data == '0);
    assign rs_mag     = (div_signed && rs_data[WIDTH-1]) ? (~rs_data + 1'b1) : rs_data;
    assign rt_mag     = (div_signed && rt_data[WIDTH-1]) ? (~rt_data + 1'b1) : rt_data;

    // Sign-extending to the full product width makes one unsigned multiply serve both forms.
    assign a_ext = {{WIDTH{mul_signed & mul_a[WIDTH-1]}}, mul_a};
    assign b_ext = {{WIDTH{mul_signed & mul_b[WIDTH-1]}}, mul_b};
    assign prod  = a_ext * b_ext;

    div_iter #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (accept && is_div && !rt_zero),
        .dividend (rs_mag),
        .divisor  (rt_mag),
        .last     (div_last),
        .quo_next (quo_next),
        .rem_next (rem_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_a      <= '0;
            mul_b      <= '0;
            mul_signed <= 1'b0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
        end else if (accept) begin
            mul_a      <= rs_data;
            mul_b      <= rt_data;
            mul_signed <= (op_code == OP_MULT);
            q_neg      <= div_signed && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
            r_neg      <= div_signed && rs_data[WIDTH-1];
        end
    end

    always_comb begin
        state_nxt    = state;
        hi_wea_nxt   = 1'b0;
        lo_wea_nxt   = 1'b0;
        hi_wdata_nxt = '0;
        lo_wdata_nxt = '0;
        done_nxt     = 1'b0;
        div_zero_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (op_code)
                        OP_MULT, OP_MULTU: state_nxt = S_MUL;
                        OP_DIV, OP_DIVU: begin
                            if (rt_zero) begin
                                state_nxt    = S_WB;
                                hi_wea_nxt   = 1'b1;
                                lo_wea_nxt   = 1'b1;
                                hi_wdata_nxt = rs_data;
                                lo_wdata_nxt = '1;
                                done_nxt     = 1'b1;
                                div_zero_nxt = 1'b1;
                            end else begin
                                state_nxt = S_DIV;
                            end
                        end
                        OP_MTHI: begin
                            state_nxt    = S_WB;
                            hi_wea_nxt   = 1'b1;
                            hi_wdata_nxt = rs_data;
                            done_nxt     = 1'b1;
                        end
                        OP_MTLO: begin
                            state_nxt    = S_WB;
                            lo_wea_nxt   = 1'b1;
                            lo_wdata_nxt = rs_data;
                            done_nxt     = 1'b1;
                        end
                        default: state_nxt = S_IDLE;
                    endcase
                end
            end
            S_MUL: begin
                if (cnt == MUL_LAST) begin
                    state_nxt    = S_WB;
                    hi_wea_nxt   = 1'b1;
                    lo_wea_nxt   = 1'b1;
                    hi_wdata_nxt = prod[2*WIDTH-1:WIDTH];
                    lo_wdata_nxt = prod[WIDTH-1:0];
                    done_nxt     = 1'b1;
                end
            end
            S_DIV: begin
                if (div_last) begin
                    state_nxt    = S_WB;
                    hi_wea_nxt   = 1'b1;
                    lo_wea_nxt   = 1'b1;
                    hi_wdata_nxt = r_neg ? (~rem_next + 1'b1) : rem_next;
                    lo_wdata_nxt = q_neg ? (~quo_next + 1'b1) : quo_next;
                    done_nxt     = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            hi_wea   <= 1'b0;
            lo_wea   <= 1'b0;
            hi_wdata <= '0;
            lo_wdata <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= ((state == S_MUL) && (state_nxt == S_MUL)) ? cnt + 1'b1 : 3'd0;
            hi_wea   <= hi_wea_nxt;
            lo_wea   <= lo_wea_nxt;
            hi_wdata <= hi_wdata_nxt;
            lo_wdata <= lo_wdata_nxt;
            done     <= done_nxt;
            div_zero <= div_zero_nxt;
        end
    end

endmodule
`default_nettype wire
